// File: rtl/arit_div_pkg.sv
// arit_div_pkg: shared word width and FSM state encoding for the divider
package arit_div_pkg;
   localparam int DIV_WORD = 16;
   typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;
endpackage

// File: rtl/arit_div_step.sv
// arit_div_step: one restoring-division step, trial subtract as r + ~dvs + 1
//   r     : partial remainder before the step
//   d_bit : next dividend bit shifted in
//   dvs   : divisor (magnitude)
//   r_nx  : partial remainder after the step
//   q_bit : quotient bit (1 = trial subtract did not borrow)
module arit_div_step #(
   parameter int SIZE = 16
) (
   input  logic [SIZE-1:0] r,
   input  logic            d_bit,
   input  logic [SIZE-1:0] dvs,
   output logic [SIZE-1:0] r_nx,
   output logic            q_bit
);
   logic [SIZE:0]   sh;
   logic [SIZE+1:0] diff;
   logic            unused_msb;
   assign sh = {r, d_bit};
   // carry out of the extended sum is the "no borrow" indication
   assign diff = {1'b0, sh} + {1'b0, ~{1'b0, dvs}} + (SIZE+2)'(1);
   assign q_bit = diff[SIZE+1];
   // a kept difference is below dvs, so it always fits SIZE bits
   assign r_nx = q_bit ? diff[SIZE-1:0] : sh[SIZE-1:0];
   assign unused_msb = diff[SIZE];
endmodule

// File: rtl/arit_div.sv
// arit_div: multi-cycle restoring divider, one quotient bit per clock
//   clk   : clock           rst_n : synchronous active-low reset
//   start : request (IDLE only)   dvd/dvs : dividend/divisor
//   bw    : 1 = byte op on low SIZE/2 bits, 0 = word op
//   sgn   : signed request, honoured only when ARIT_DIV_SIGNED_EN is defined
//   busy  : op in flight (through the done cycle)   done : result pulse
//   quo/rem : quotient/remainder, held until the next result
//   div0  : last op divided by zero
module arit_div
   import arit_div_pkg::*;
#(
   parameter int SIZE = DIV_WORD
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] dvd,
   input  logic [SIZE-1:0] dvs,
   input  logic            bw,
   input  logic            sgn,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] quo,
   output logic [SIZE-1:0] rem,
   output logic            div0
);
   localparam int HALF = SIZE / 2;
   localparam int CW = $clog2(SIZE) + 1;
   state_t          state, state_nx;
   logic [SIZE-1:0] d_q, r_q, dvs_q, r_nx, quo_q, rem_q;
   logic [SIZE-1:0] mask, mask_q, dvd_m, dvs_m, dvd_a, dvs_a;
   logic [CW-1:0]   cnt;
   logic            bw_q, sgn_q, neg_q, neg_r, div0_q;
   logic            sgn_op, dvd_s, dvs_s, zero_dvs, accept, last, qbit;
`ifdef ARIT_DIV_SIGNED_EN
   assign sgn_op = sgn;
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
   assign sgn_op = 1'b0;
`endif
   assign mask = {{(SIZE-HALF){~bw}}, {HALF{1'b1}}};
   assign mask_q = {{(SIZE-HALF){~bw_q}}, {HALF{1'b1}}};
   assign dvd_m = dvd & mask;
   assign dvs_m = dvs & mask;
   assign dvd_s = bw ? dvd[HALF-1] : dvd[SIZE-1];
   assign dvs_s = bw ? dvs[HALF-1] : dvs[SIZE-1];
   // magnitudes within the active width; the most-negative value maps to itself
   assign dvd_a = (sgn_op && dvd_s) ? ((-dvd_m) & mask) : dvd_m;
   assign dvs_a = (sgn_op && dvs_s) ? ((-dvs_m) & mask) : dvs_m;
   assign zero_dvs = dvs_m == '0;
   assign accept = (state == IDLE) && start;
   assign last = cnt == CW'(1);
   assign quo = quo_q;
   assign rem = rem_q;
   assign div0 = div0_q;
   arit_div_step #(.SIZE(SIZE)) u_step (
      .r     (r_q),
      .d_bit (d_q[SIZE-1]),
      .dvs   (dvs_q),
      .r_nx  (r_nx),
      .q_bit (qbit)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = start ? (zero_dvs ? FIN : CALC) : IDLE;
         CALC:    state_nx = last ? (sgn_q ? FIX : FIN) : CALC;
         FIX:     state_nx = FIN;
         default: state_nx = IDLE;
      endcase
      busy = state != IDLE;
      done = state == FIN;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q    <= '0;
         r_q    <= '0;
         dvs_q  <= '0;
         cnt    <= '0;
         bw_q   <= 1'b0;
         sgn_q  <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         quo_q  <= '0;
         rem_q  <= '0;
         div0_q <= 1'b0;
      end else begin
         if (accept) begin
            // byte operands sit in the top half so the msb feeds the step in both modes
            d_q    <= bw ? {dvd_a[HALF-1:0], {HALF{1'b0}}} : dvd_a;
            r_q    <= '0;
            dvs_q  <= dvs_a;
            cnt    <= bw ? CW'(HALF) : CW'(SIZE);
            bw_q   <= bw;
            sgn_q  <= sgn_op && !zero_dvs;
            neg_q  <= sgn_op && (dvd_s ^ dvs_s);
            neg_r  <= sgn_op && dvd_s;
            div0_q <= zero_dvs;
            if (zero_dvs) begin
               quo_q <= mask;
               rem_q <= dvd_m;
            end
         end
         if (state == CALC) begin
            d_q <= {d_q[SIZE-2:0], qbit};
            r_q <= r_nx;
            cnt <= cnt - CW'(1);
            if (last && !sgn_q) begin
               quo_q <= {d_q[SIZE-2:0], qbit};
               rem_q <= r_nx;
            end
         end
         if (state == FIX) begin
            quo_q <= (neg_q ? -d_q : d_q) & mask_q;
            rem_q <= (neg_r ? -r_q : r_q) & mask_q;
         end
      end
   end
endmodule

// File: tb/tb_arit_div.sv
// tb_arit_div: directed and random checks of arit_div against an arithmetic model
module tb_arit_div;
`ifdef ARIT_DIV_SIGNED_EN
   localparam bit SIGNED = 1'b1;
`else
   localparam bit SIGNED = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        bw = 1'b0;
   logic        sgn = 1'b0;
   logic [15:0] dvd = '0;
   logic [15:0] dvs = '0;
   logic        busy, done, div0;
   logic [15:0] quo, rem;
   int          passed = 0;
   int          total = 0;

   arit_div dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .dvd   (dvd),
      .dvs   (dvs),
      .bw    (bw),
      .sgn   (sgn),
      .busy  (busy),
      .done  (done),
      .quo   (quo),
      .rem   (rem),
      .div0  (div0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // quotient/remainder from plain integer arithmetic over the active width
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic w,
                                 input logic s, output logic [15:0] q, output logic [15:0] r,
                                 output logic z, output int lat);
      int m, ua, ub, sa, sb;
      m = w ? 255 : 65535;
      ua = int'(a) & m;
      ub = int'(b) & m;
      z = ub == 0;
      lat = 1;
      q = 16'(m);
      r = 16'(ua);
      if (!z) begin
         lat = (w ? 8 : 16) + 1;
         q = 16'(ua / ub);
         r = 16'(ua % ub);
         if (s && SIGNED) begin
            sa = ua > m / 2 ? ua - m - 1 : ua;
            sb = ub > m / 2 ? ub - m - 1 : ub;
            q = 16'((sa / sb) & m);
            r = 16'((sa % sb) & m);
            lat++;
         end
      end
   endfunction

   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic w, input logic s);
      @(negedge clk);
      dvd = a;
      dvs = b;
      bw = w;
      sgn = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, output int lat);
      lat = base;
      while (done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic w, input logic s);
      logic [15:0] eq, er;
      logic        ez;
      int          el, lat;
      model(a, b, w, s, eq, er, ez, el);
      launch(a, b, w, s);
      chk({tag, ".busy"}, 32'(busy), 32'(1));
      wait_done(1, lat);
      chk({tag, ".lat"}, 32'(lat), 32'(el));
      chk({tag, ".quo"}, 32'(quo), 32'(eq));
      chk({tag, ".rem"}, 32'(rem), 32'(er));
      chk({tag, ".div0"}, 32'(div0), 32'(ez));
      @(negedge clk);
      chk({tag, ".idle"}, 32'(busy), 32'(0));
   endtask

   initial begin
      logic [15:0] a, b;
      logic        w, s;
      int          lat;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'(0));
      chk("rst.done", 32'(done), 32'(0));
      chk("rst.div0", 32'(div0), 32'(0));
      chk("rst.quo", 32'(quo), 32'(0));
      chk("rst.rem", 32'(rem), 32'(0));
      rst_n = 1'b1;
      op("t1", 16'd100, 16'd7, 1'b0, 1'b0);
      chk("t1.q14", 32'(quo), 32'(14));
      op("t2", 16'h12FF, 16'h0010, 1'b1, 1'b0);
      chk("t2.q0f", 32'(quo), 32'h000F);
      op("t3", 16'h1234, 16'h0000, 1'b0, 1'b0);
      chk("t3.qffff", 32'(quo), 32'hFFFF);
      op("t3b", 16'hABCD, 16'h0100, 1'b1, 1'b0);
      chk("t3b.q00ff", 32'(quo), 32'h00FF);
      // start while busy must be ignored
      launch(16'd100, 16'd7, 1'b0, 1'b0);
      @(negedge clk);
      dvd = 16'd50;
      dvs = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, lat);
      chk("t4.lat", 32'(lat), 32'(17));
      chk("t4.quo", 32'(quo), 32'(14));
      chk("t4.rem", 32'(rem), 32'(2));
      // start held through FIN is ignored there, then accepted back-to-back in IDLE
      dvd = 16'd77;
      dvs = 16'd4;
      start = 1'b1;
      @(negedge clk);
      chk("b2b.fin_ignored", 32'(busy), 32'(0));
      @(negedge clk);
      start = 1'b0;
      chk("b2b.accepted", 32'(busy), 32'(1));
      chk("b2b.hold_quo", 32'(quo), 32'(14));
      wait_done(1, lat);
      chk("b2b.lat", 32'(lat), 32'(17));
      chk("b2b.quo", 32'(quo), 32'(19));
      chk("b2b.rem", 32'(rem), 32'(1));
      // reset in the middle of a calculation
      launch(16'd100, 16'd7, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5.busy", 32'(busy), 32'(0));
      chk("t5.quo", 32'(quo), 32'(0));
      chk("t5.rem", 32'(rem), 32'(0));
      op("t5b", 16'd9, 16'd3, 1'b0, 1'b0);
      chk("t5b.q3", 32'(quo), 32'(3));
`ifdef ARIT_DIV_SIGNED_EN
      op("t6", 16'hFF9C, 16'd7, 1'b0, 1'b1);
      chk("t6.qfff2", 32'(quo), 32'hFFF2);
      chk("t6.rfffe", 32'(rem), 32'hFFFE);
      op("minw", 16'h8000, 16'hFFFF, 1'b0, 1'b1);
      chk("minw.q", 32'(quo), 32'h8000);
      op("minb", 16'h0080, 16'h00FF, 1'b1, 1'b1);
      chk("minb.q", 32'(quo), 32'h0080);
      op("sdiv0", 16'hFF9C, 16'h0000, 1'b0, 1'b1);
`endif
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         w = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         op("rand", a, b, w, s);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
